// File: rtl/gameover_banner_ctrl.sv
// Game-over banner overlay: latches the match result, waits a few frames,
// then draws (optionally blinking) a colour-keyed ROM image on the VGA stream.
//
// Ports:
//   clk, rst                  pixel clock, async active-high reset
//   game_over, winner         1-cycle result pulse and 2-bit result code
//   restart                   1-cycle pulse: back to IDLE
//   hcount_in .. rgb_in       incoming VGA timing and background pixel
//   addr_p1/addr_p2/addr_dr   ROM addresses (data returns 1 clk later)
//   rgb_p1/rgb_p2/rgb_draw    ROM data
//   hcount_out .. rgb_out     VGA stream delayed by 3 clk, with overlay
//   banner_active             FSM in SHOW, aligned with the pixel outputs
module gameover_banner_ctrl #(
  parameter int unsigned X_POS        = 300,
  parameter int unsigned Y_POS        = 250,
  parameter int unsigned SHOW_DELAY   = 30,
  parameter int unsigned BLINK_FRAMES = 0,
  parameter logic [11:0] KEY_COLOR    = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_over,
  input  logic [1:0]  winner,
  input  logic        restart,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [12:0] addr_p1,
  output logic [12:0] addr_p2,
  output logic [13:0] addr_dr,
  input  logic [11:0] rgb_p1,
  input  logic [11:0] rgb_p2,
  input  logic [11:0] rgb_draw,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        banner_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam logic [1:0] WIN_DR = 2'b11;

  // Per-pixel bundle carried through S1 and S2.
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
    logic        act;
    logic        win;
    logic        vis;
    logic [1:0]  sel;
  } pix_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  win_q;
  logic [1:0]  win_d;
  logic [15:0] fcnt_q;
  logic [15:0] fcnt_d;
  logic        blink_q;
  logic        blink_d;

  logic        frame_tick;
  logic        show_c;
  logic        vis_c;

  logic        draw_sel;
  logic [31:0] img_w;
  logic [31:0] img_h;
  logic [31:0] hx;
  logic [31:0] vy;
  logic [31:0] rel_x;
  logic [31:0] rel_y;
  logic [31:0] lin;
  logic        in_win;

  logic [12:0] a_p1_d;
  logic [12:0] a_p2_d;
  logic [13:0] a_dr_d;

  pix_t        s0;
  pix_t        s1;
  pix_t        s2;

  logic [11:0] rom_pix;
  logic        ovl;

  assign frame_tick = (hcount_in == 11'd0) &&
                      (vcount_in == 11'd0);

  // ---------------- FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= WIN_DR;
      fcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
    end
  end

  // ---------------- FSM: next state
  // fcnt_q counts delay frames in ARMED and blink-phase frames in SHOW.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (restart) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (game_over) begin
            state_d = ARMED;
            win_d   = (winner == 2'b00) ? WIN_DR : winner;
            fcnt_d  = '0;
          end
        end
        ARMED: begin
          if (frame_tick) begin
            if ({16'd0, fcnt_q} == SHOW_DELAY) begin
              state_d = SHOW;
              fcnt_d  = '0;
              blink_d = 1'b1;
            end else begin
              fcnt_d = fcnt_q + 16'd1;
            end
          end
        end
        SHOW: begin
          if (frame_tick && (BLINK_FRAMES != 0)) begin
            if ({16'd0, fcnt_q} == BLINK_FRAMES - 32'd1) begin
              fcnt_d  = '0;
              blink_d = ~blink_q;
            end else begin
              fcnt_d = fcnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------- FSM: outputs
  always_comb begin
    show_c = (state_q == SHOW);
    vis_c  = show_c && blink_q;
  end

  // ---------------- window and address
  // 32-bit intermediates so the subtractions never wrap before the
  // range checks; the product is truncated onto the port width.
  always_comb begin
    draw_sel = (win_q == WIN_DR);
    img_w    = draw_sel ? 32'd201 : 32'd200;
    img_h    = draw_sel ? 32'd56 : 32'd34;
    hx       = {21'd0, hcount_in};
    vy       = {21'd0, vcount_in};
    in_win   = (hx >= X_POS) &&
               (hx < X_POS + img_w) &&
               (vy >= Y_POS) &&
               (vy < Y_POS + img_h);
    rel_x    = hx - X_POS;
    rel_y    = vy - Y_POS;
    lin      = rel_y * img_w + rel_x;
  end

  // ROM is addressed only while the banner is actually drawn, so the
  // address ports stay at 0 in IDLE/ARMED and in blink-off frames.
  always_comb begin
    a_p1_d = '0;
    a_p2_d = '0;
    a_dr_d = '0;
    if (vis_c && in_win) begin
      unique case (1'b1)
        (win_q == WIN_P1): a_p1_d = lin[12:0];
        (win_q == WIN_P2): a_p2_d = lin[12:0];
        default:           a_dr_d = lin[13:0];
      endcase
    end
  end

  always_comb begin
    s0     = '0;
    s0.hc  = hcount_in;
    s0.vc  = vcount_in;
    s0.hs  = hsync_in;
    s0.hb  = hblnk_in;
    s0.vs  = vsync_in;
    s0.vb  = vblnk_in;
    s0.rgb = rgb_in;
    s0.act = show_c;
    s0.win = in_win;
    s0.vis = vis_c;
    s0.sel = win_q;
  end

  // ---------------- S1 / S2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p1 <= '0;
      addr_p2 <= '0;
      addr_dr <= '0;
      s1      <= '0;
      s2      <= '0;
    end else begin
      addr_p1 <= a_p1_d;
      addr_p2 <= a_p2_d;
      addr_dr <= a_dr_d;
      s1      <= s0;
      s2      <= s1;
    end
  end

  // ---------------- S3: ROM data is valid now, merge overlay
  always_comb begin
    unique case (1'b1)
      (s2.sel == WIN_P1): rom_pix = rgb_p1;
      (s2.sel == WIN_P2): rom_pix = rgb_p2;
      default:            rom_pix = rgb_draw;
    endcase
    ovl = s2.vis && s2.win &&
          (rom_pix != KEY_COLOR) &&
          !s2.hb && !s2.vb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out    <= '0;
      vcount_out    <= '0;
      hsync_out     <= 1'b0;
      hblnk_out     <= 1'b0;
      vsync_out     <= 1'b0;
      vblnk_out     <= 1'b0;
      rgb_out       <= '0;
      banner_active <= 1'b0;
    end else begin
      hcount_out    <= s2.hc;
      vcount_out    <= s2.vc;
      hsync_out     <= s2.hs;
      hblnk_out     <= s2.hb;
      vsync_out     <= s2.vs;
      vblnk_out     <= s2.vb;
      rgb_out       <= ovl ? rom_pix : s2.rgb;
      banner_active <= s2.act;
    end
  end

endmodule

// File: tb/tb_gameover_banner_ctrl.sv
// Bench for gameover_banner_ctrl: scripted sparse raster, behavioural ROM,
// scoreboard on the 3-clk pixel outputs, direct checks on ROM addresses.
module tb_gameover_banner_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_over = 1'b0;
  logic [1:0]  winner = 2'b00;
  logic        restart = 1'b0;
  logic [10:0] hcount_in = '0;
  logic        hsync_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic [10:0] vcount_in = '0;
  logic        vsync_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [12:0] addr_p1;
  logic [12:0] addr_p2;
  logic [13:0] addr_dr;
  logic [11:0] rgb_p1 = '0;
  logic [11:0] rgb_p2 = '0;
  logic [11:0] rgb_draw = '0;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic        banner_active;

  gameover_banner_ctrl #(
    .X_POS(300),
    .Y_POS(250),
    .SHOW_DELAY(2),
    .BLINK_FRAMES(4),
    .KEY_COLOR(12'hF0F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_over(game_over),
    .winner(winner),
    .restart(restart),
    .hcount_in(hcount_in),
    .hsync_in(hsync_in),
    .hblnk_in(hblnk_in),
    .vcount_in(vcount_in),
    .vsync_in(vsync_in),
    .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .addr_p1(addr_p1),
    .addr_p2(addr_p2),
    .addr_dr(addr_dr),
    .rgb_p1(rgb_p1),
    .rgb_p2(rgb_p2),
    .rgb_draw(rgb_draw),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out(hsync_out),
    .hblnk_out(hblnk_out),
    .vsync_out(vsync_out),
    .vblnk_out(vblnk_out),
    .rgb_out(rgb_out),
    .banner_active(banner_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [26:0] misc;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic key_all = 1'b0;
  bit   exp_show = 1'b0;
  bit   exp_vis = 1'b0;
  int   exp_win = 3;

  int ph [11] = '{300, 499, 335, 400, 400, 500,
                  500, 501, 300, 299, 100};
  int pv [11] = '{250, 283, 250, 260, 270, 305,
                  283, 250, 284, 250, 100};
  int pb [11] = '{0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0};

  // Behavioural ROMs, 1 clk read latency.
  always @(posedge clk) begin
    rgb_p1   <= key_all ? 12'hF0F : {4'h1, addr_p1[7:0]};
    rgb_p2   <= key_all ? 12'hF0F : {4'h2, addr_p2[7:0]};
    rgb_draw <= key_all ? 12'hF0F : {4'h3, addr_dr[7:0]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      ce = q.pop_front();
      chk("rgb_out", {20'd0, rgb_out}, {20'd0, ce.rgb});
      chk("timing", {5'd0, hcount_out, vcount_out,
                     hsync_out, hblnk_out, vsync_out,
                     vblnk_out, banner_active},
          {5'd0, ce.misc});
    end
  end

  task automatic pix(input int h, input int v,
                     input bit hb, input bit vb);
    bit          drw;
    int          w;
    int          hh;
    bit          inw;
    bit          on;
    int          a;
    int          a1;
    int          a2;
    int          ad;
    logic [11:0] rom;
    logic [11:0] rin;
    logic        hs;
    logic        vs;
    exp_t        e;
    rin = 12'($urandom);
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = hs;
    vsync_in  = vs;
    rgb_in    = rin;
    drw = (exp_win == 3);
    w   = drw ? 201 : 200;
    hh  = drw ? 56 : 34;
    inw = (h >= 300) && (h < 300 + w) &&
          (v >= 250) && (v < 250 + hh);
    a   = (v - 250) * w + (h - 300);
    on  = exp_vis && inw;
    a1  = (on && exp_win == 1) ? a : 0;
    a2  = (on && exp_win == 2) ? a : 0;
    ad  = (on && exp_win == 3) ? a : 0;
    rom = key_all ? 12'hF0F : {4'(exp_win), 8'(a)};
    e.due  = cyc + 3;
    e.rgb  = (on && rom != 12'hF0F && !hb && !vb) ? rom : rin;
    e.misc = {11'(h), 11'(v), hs, hb, vs, vb, exp_show};
    q.push_back(e);
    @(posedge clk);
    #1;
    chk("addr_p1", {19'd0, addr_p1}, 32'(a1));
    chk("addr_p2", {19'd0, addr_p2}, 32'(a2));
    chk("addr_dr", {18'd0, addr_dr}, 32'(ad));
  endtask

  task automatic frame(input bit nshow, input bit nvis);
    pix(0, 0, 1'b0, 1'b0);
    exp_show = nshow;
    exp_vis  = nvis;
    for (int i = 0; i < 11; i++)
      pix(ph[i], pv[i], pb[i][1], pb[i][0]);
  endtask

  task automatic pulse(input bit go, input bit rs,
                       input logic [1:0] w);
    game_over = go;
    restart   = rs;
    winner    = w;
    pix(5, 5, 1'b0, 1'b0);
    game_over = 1'b0;
    restart   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    hcount_in = 11'd1000;
    vcount_in = 11'd1000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {20'd0, rgb_out}, 32'd0);
    chk("rst_act", {31'd0, banner_active}, 32'd0);
    chk("rst_addr", {5'd0, addr_p1, addr_dr}, 32'd0);
    chk("rst_hc", {21'd0, hcount_out}, 32'd0);
    rst = 1'b0;

    // idle: pass-through, no addresses
    frame(1'b0, 1'b0);

    // P1 result; banner on third frame tick
    pulse(1'b1, 1'b0, 2'b01);
    exp_win = 1;
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b1);

    // whole image keyed out
    key_all = 1'b1;
    frame(1'b1, 1'b1);
    key_all = 1'b0;

    // game_over in SHOW must not relatch
    pulse(1'b1, 1'b0, 2'b10);
    frame(1'b1, 1'b1);
    frame(1'b1, 1'b1);

    // blink: 4 off, 4 on, then off
    repeat (4) frame(1'b1, 1'b0);
    repeat (4) frame(1'b1, 1'b1);
    frame(1'b1, 1'b0);

    // restart beats game_over
    pulse(1'b1, 1'b1, 2'b10);
    exp_show = 1'b0;
    exp_vis  = 1'b0;
    repeat (3) frame(1'b0, 1'b0);

    // winner 00 -> draw image, phase starts on
    pulse(1'b1, 1'b0, 2'b00);
    exp_win = 3;
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b1);

    // async reset mid-line while showing
    pix(600, 250, 1'b0, 1'b0);
    pix(601, 250, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rgb", {20'd0, rgb_out}, 32'd0);
    chk("mid_rst_act", {31'd0, banner_active}, 32'd0);
    chk("mid_rst_hc", {21'd0, hcount_out}, 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_show = 1'b0;
    exp_vis  = 1'b0;
    exp_win  = 3;
    frame(1'b0, 1'b0);

    hcount_in = 11'd1000;
    vcount_in = 11'd1000;
    repeat (5) @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
